mc_sram_bridge: RTL

Parametrised MCU external-memory-controller slave: an asynchronous SRAM-style bus (CE/OE/WE, byte lanes) from the MCU is mapped onto an internal dual-port buffer that FPGA logic can also access. It is the next generation of the bus-pirate MCU SRAM test block. It adds strobe synchronisation, edge-qualified write commit, byte-lane masking, protocol-error detection, a fabric-side port and write/collision status. The pad tristate stays outside this block; the block drives data-out and output-enable only.

---
 rtl/mc_sram_bridge.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mc_sram_bridge
// Description : MCU asynchronous-SRAM slave mapped onto a dual-port word
//               buffer. MCU strobes are synchronised into the fabric clock,
//               writes commit on the WE rising edge with byte-lane masking,
//               illegal OE+WE overlap is flagged, and a fabric-side port
//               shares the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_sram_bridge #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mc_ce,
    input  logic                       mc_oe,
    input  logic                       mc_we,
    input  logic [MC_DATA_WIDTH/8-1:0] mc_bl,
    input  logic [MC_ADD_WIDTH-1:0]    mc_add,
    input  logic [MC_DATA_WIDTH-1:0]   mc_din,
    output logic [MC_DATA_WIDTH-1:0]   mc_dout,
    output logic                       mc_dout_en,
    input  logic [MC_ADD_WIDTH-1:0]    usr_addr,
    input  logic                       usr_wr_en,
    input  logic [MC_DATA_WIDTH-1:0]   usr_wr_data,
    output logic [MC_DATA_WIDTH-1:0]   usr_rd_data,
    output logic                       mc_wr_pulse,
    output logic [15:0]                wr_count,
    output logic                       proto_err,
    output logic                       usr_collision
);

    localparam int c_LANES = MC_DATA_WIDTH / 8;
    localparam int c_DEPTH = 2 ** MC_ADD_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Synchroniser chains; the last stage is the only view the FSM uses
    logic [SYNC_STAGES-1:0]   r_ce_sync;
    logic [SYNC_STAGES-1:0]   r_oe_sync;
    logic [SYNC_STAGES-1:0]   r_we_sync;
    logic [c_LANES-1:0]       r_bl_sync  [SYNC_STAGES];
    logic [MC_ADD_WIDTH-1:0]  r_add_sync [SYNC_STAGES];
    logic [MC_DATA_WIDTH-1:0] r_din_sync [SYNC_STAGES];

    logic                     w_s_ce;
    logic                     w_s_oe;
    logic                     w_s_we;
    logic [c_LANES-1:0]       w_s_bl;
    logic [MC_ADD_WIDTH-1:0]  w_s_add;
    logic [MC_DATA_WIDTH-1:0] w_s_din;

    // Shared word buffer (not cleared by reset)
    logic [MC_DATA_WIDTH-1:0] r_mem [c_DEPTH];

    state_t                   r_state;
    logic [MC_ADD_WIDTH-1:0]  r_hold_add;
    logic [MC_DATA_WIDTH-1:0] r_hold_din;
    logic [c_LANES-1:0]       r_hold_bl;
    logic [MC_DATA_WIDTH-1:0] r_mc_dout;
    logic                     r_mc_dout_en;
    logic                     r_mc_wr_pulse;
    logic [15:0]              r_wr_count;
    logic                     r_proto_err;
    logic                     r_usr_collision;
    logic [MC_DATA_WIDTH-1:0] r_usr_rd_data;

    assign w_s_ce  = r_ce_sync[SYNC_STAGES-1];
    assign w_s_oe  = r_oe_sync[SYNC_STAGES-1];
    assign w_s_we  = r_we_sync[SYNC_STAGES-1];
    assign w_s_bl  = r_bl_sync[SYNC_STAGES-1];
    assign w_s_add = r_add_sync[SYNC_STAGES-1];
    assign w_s_din = r_din_sync[SYNC_STAGES-1];

    // Shift every MCU pad input through the synchroniser; strobes idle high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ce_sync <= '1;
            r_oe_sync <= '1;
            r_we_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_bl_sync[i]  <= '1;
                r_add_sync[i] <= '0;
                r_din_sync[i] <= '0;
            end
        end else begin
            r_ce_sync     <= {r_ce_sync[SYNC_STAGES-2:0], mc_ce};
            r_oe_sync     <= {r_oe_sync[SYNC_STAGES-2:0], mc_oe};
            r_we_sync     <= {r_we_sync[SYNC_STAGES-2:0], mc_we};
            r_bl_sync[0]  <= mc_bl;
            r_add_sync[0] <= mc_add;
            r_din_sync[0] <= mc_din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_bl_sync[i]  <= r_bl_sync[i-1];
                r_add_sync[i] <= r_add_sync[i-1];
                r_din_sync[i] <= r_din_sync[i-1];
            end
        end
    end

    // MCU access sequencer with registered pad/status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_hold_add      <= '0;
            r_hold_din      <= '0;
            r_hold_bl       <= '1;
            r_mc_dout       <= '0;
            r_mc_dout_en    <= 1'b0;
            r_mc_wr_pulse   <= 1'b0;
            r_wr_count      <= 16'd0;
            r_proto_err     <= 1'b0;
            r_usr_collision <= 1'b0;
        end else begin
            r_mc_wr_pulse   <= 1'b0;
            r_usr_collision <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mc_dout_en <= 1'b0;
                    if (!w_s_ce) begin
                        if (!w_s_oe && !w_s_we) begin
                            // Both strobes active: flag it and ignore the cycle
                            r_proto_err <= 1'b1;
                        end else if (!w_s_oe) begin
                            r_state      <= ST_READ;
                            r_mc_dout    <= r_mem[w_s_add];
                            r_mc_dout_en <= 1'b1;
                        end else if (!w_s_we) begin
                            r_state    <= ST_WRITE;
                            r_hold_add <= w_s_add;
                            r_hold_din <= w_s_din;
                            r_hold_bl  <= w_s_bl;
                        end
                    end
                end
                ST_READ: begin
                    if (w_s_oe || w_s_ce) begin
                        r_state      <= ST_IDLE;
                        r_mc_dout_en <= 1'b0;
                    end else begin
                        // Re-read every cycle so address changes are followed
                        r_mc_dout    <= r_mem[w_s_add];
                        r_mc_dout_en <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!w_s_oe) begin
                        r_proto_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_s_ce) begin
                        // CE released before WE: abandon the write
                        r_state <= ST_IDLE;
                    end else if (w_s_we) begin
                        // WE rising edge: holding registers keep last WE-low sample
                        r_state       <= ST_COMMIT;
                        r_mc_wr_pulse <= 1'b1;
                        r_wr_count    <= r_wr_count + 16'd1;
                    end else begin
                        r_hold_add <= w_s_add;
                        r_hold_din <= w_s_din;
                        r_hold_bl  <= w_s_bl;
                    end
                end
                ST_COMMIT: begin
                    r_usr_collision <= usr_wr_en && (usr_addr == r_hold_add);
                    r_state         <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer writes: fabric word first, MCU enabled lanes override on overlap
    always_ff @(posedge clock) begin
        if (usr_wr_en) begin
            r_mem[usr_addr] <= usr_wr_data;
        end
        if (r_state == ST_COMMIT) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (!r_hold_bl[i]) begin
                    r_mem[r_hold_add][i*8 +: 8] <= r_hold_din[i*8 +: 8];
                end
            end
        end
    end

    // Fabric read port, read-first with one cycle of latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_usr_rd_data <= '0;
        end else begin
            r_usr_rd_data <= r_mem[usr_addr];
        end
    end

    assign mc_dout       = r_mc_dout;
    assign mc_dout_en    = r_mc_dout_en;
    assign usr_rd_data   = r_usr_rd_data;
    assign mc_wr_pulse   = r_mc_wr_pulse;
    assign wr_count      = r_wr_count;
    assign proto_err     = r_proto_err;
    assign usr_collision = r_usr_collision;

endmodule
`default_nettype wire
